pixel_compose_pipe: RTL and testbench

- Pipelined read-modify-write compositor for the GPU line back buffer.
- Accepts one tile-row beat per cycle, aligns its pixels to a line-buffer word using a fine offset and an internally held carry of the previous beat's tail pixels, then z-merges the result into the line buffer.
- Includes a line-clear sequencer. Sits between the tile fetch unit and the dual-port line buffer RAM.

---
 rtl/gpu_pkg.sv | 41 ++++
 rtl/pixel_align.sv | 37 +++
 rtl/pixel_compose_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_compose_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared geometry for the GPU line back buffer: default sizes, word width and
// the bit positions of the per-pixel fields inside one line-buffer word.
package gpu_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int TILE_PIX     = 8;
  localparam int IDX_BITS     = 4;
  localparam int PAL_BITS     = 4;
  localparam int Z_BITS       = 2;
  localparam int ADDR_BITS    = 6;
  localparam int DEPTH        = 40;

  // Colour index that never overrides an already-drawn pixel.
  localparam int IDX_TRANSPARENT = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } clr_state_e;

  function automatic int lb_width(input int ppw, input int pal, input int idx, input int zb);
    return ppw * (pal + idx + zb + 1);
  endfunction

  function automatic int data_lsb(input int k, input int pal, input int idx);
    return k * (pal + idx);
  endfunction

  function automatic int upd_lsb(input int ppw, input int pal, input int idx);
    return ppw * (pal + idx);
  endfunction

  function automatic int z_lsb(input int k, input int ppw, input int pal, input int idx,
                               input int zb);
    return ppw * (pal + idx + 1) + k * zb;
  endfunction

  localparam int LB_W = lb_width(PIX_PER_WORD, PAL_BITS, IDX_BITS, Z_BITS);

endpackage

// File: rtl/pixel_align.sv
// Picks one line-buffer word worth of pixels out of the tile beat, extended
// on the low side by the tail pixels carried over from the previous beat.
module pixel_align #(
  parameter int PIX_PER_WORD = 4,
  parameter int TILE_PIX     = 8,
  parameter int IDX_BITS     = 4,
  parameter int OFF_W        = 2
) (
  input  logic [TILE_PIX*IDX_BITS-1:0]       tile_i,
  input  logic [(PIX_PER_WORD-1)*IDX_BITS-1:0] carry_i,
  input  logic                               start_i,
  input  logic                               upper_i,
  input  logic [OFF_W-1:0]                   offset_i,
  output logic [PIX_PER_WORD*IDX_BITS-1:0]   pix_o
);

  localparam int CAR_W = (PIX_PER_WORD - 1) * IDX_BITS;
  localparam int STR_N = PIX_PER_WORD - 1 + TILE_PIX;

  logic [CAR_W-1:0]          carry_eff;
  logic [STR_N*IDX_BITS-1:0] stream;

  // Stream entry PIX_PER_WORD-1 is tile pixel 0; lower entries are the carry.
  assign carry_eff = start_i ? '0 : carry_i;
  assign stream    = {tile_i, carry_eff};

  always_comb begin
    int sel;
    pix_o = '0;
    sel   = 0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      sel = k + PIX_PER_WORD - 1 - int'(offset_i) + (upper_i ? TILE_PIX - PIX_PER_WORD : 0);
      pix_o[k*IDX_BITS +: IDX_BITS] = stream[sel*IDX_BITS +: IDX_BITS];
    end
  end

endmodule

// File: rtl/pixel_compose_pipe.sv
// Two-stage read-modify-write compositor into the line back buffer, with a
// line-clear sequencer. Define PIXEL_COMPOSE_STATS_EN for pixel statistics.
module pixel_compose_pipe
  import gpu_pkg::*;
#(
  parameter int PIX_PER_WORD = gpu_pkg::PIX_PER_WORD,
  parameter int TILE_PIX     = gpu_pkg::TILE_PIX,
  parameter int IDX_BITS     = gpu_pkg::IDX_BITS,
  parameter int PAL_BITS     = gpu_pkg::PAL_BITS,
  parameter int Z_BITS       = gpu_pkg::Z_BITS,
  parameter int ADDR_BITS    = gpu_pkg::ADDR_BITS,
  parameter int DEPTH        = gpu_pkg::DEPTH,
  localparam int OFF_W       = $clog2(PIX_PER_WORD),
  localparam int LBW         = lb_width(PIX_PER_WORD, PAL_BITS, IDX_BITS, Z_BITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_start,
  input  logic                         in_upper,
  input  logic [OFF_W-1:0]             in_offset,
  input  logic [Z_BITS-1:0]            in_z,
  input  logic [PAL_BITS-1:0]          in_palette,
  input  logic [TILE_PIX*IDX_BITS-1:0] in_tile,
  input  logic [ADDR_BITS-1:0]         in_addr,
  output logic                         rd_en,
  output logic [ADDR_BITS-1:0]         rd_addr,
  input  logic [LBW-1:0]               rd_data,
  output logic                         wr_en,
  output logic [ADDR_BITS-1:0]         wr_addr,
  output logic [LBW-1:0]               wr_data,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done
`ifdef PIXEL_COMPOSE_STATS_EN
  ,
  output logic [15:0]                  stat_written,
  output logic [15:0]                  stat_overdraw
`endif
);

  localparam int CAR_W = (PIX_PER_WORD - 1) * IDX_BITS;
  localparam int PIX_W = PIX_PER_WORD * IDX_BITS;
  localparam int DW    = PAL_BITS + IDX_BITS;
  localparam int UPD_L = upd_lsb(PIX_PER_WORD, PAL_BITS, IDX_BITS);

  clr_state_e            state_q;
  logic [ADDR_BITS-1:0]  cnt_q;
  logic                  done_q;
  logic [CAR_W-1:0]      carry_q;
  logic                  vld_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [Z_BITS-1:0]     z_q;
  logic [PAL_BITS-1:0]   pal_q;
  logic [PIX_W-1:0]      pix_q;
  logic                  prev_we_q;
  logic [ADDR_BITS-1:0]  prev_addr_q;
  logic [LBW-1:0]        prev_data_q;

  logic                    accept;
  logic [PIX_W-1:0]        pix_d;
  logic [LBW-1:0]          old_w;
  logic [LBW-1:0]          merged;
  logic [PIX_PER_WORD-1:0] old_upd_v;
  logic [PIX_PER_WORD-1:0] new_upd_v;
  logic [PIX_PER_WORD-1:0] nz_v;

  assign in_ready   = (state_q == ST_RUN) & ~clear_start;
  assign accept     = in_valid & in_ready;
  assign rd_en      = accept;
  assign rd_addr    = accept ? in_addr : '0;
  assign clear_busy = (state_q != ST_RUN);
  assign clear_done = done_q;

  pixel_align #(
    .PIX_PER_WORD(PIX_PER_WORD),
    .TILE_PIX    (TILE_PIX),
    .IDX_BITS    (IDX_BITS),
    .OFF_W       (OFF_W)
  ) u_align (
    .tile_i  (in_tile),
    .carry_i (carry_q),
    .start_i (in_start),
    .upper_i (in_upper),
    .offset_i(in_offset),
    .pix_o   (pix_d)
  );

  // ---- stage 2: z-merge against the stored word (or the write still in flight)
  always_comb begin
    old_w     = (prev_we_q && (prev_addr_q == addr_q)) ? prev_data_q : rd_data;
    merged    = old_w;
    old_upd_v = '0;
    new_upd_v = '0;
    nz_v      = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      old_upd_v[k] = old_w[UPD_L + k];
      nz_v[k]      = (pix_q[k*IDX_BITS +: IDX_BITS] != IDX_BITS'(IDX_TRANSPARENT));
      new_upd_v[k] = ~old_upd_v[k] |
                     (nz_v[k] & (z_q > old_w[z_lsb(k, PIX_PER_WORD, PAL_BITS, IDX_BITS, Z_BITS) +: Z_BITS]));
      if (new_upd_v[k]) begin
        merged[data_lsb(k, PAL_BITS, IDX_BITS) +: DW] = {pal_q, pix_q[k*IDX_BITS +: IDX_BITS]};
        merged[z_lsb(k, PIX_PER_WORD, PAL_BITS, IDX_BITS, Z_BITS) +: Z_BITS] = z_q;
      end
      merged[UPD_L + k] = new_upd_v[k] | old_upd_v[k];
    end
  end

  assign wr_en   = vld_q | (state_q == ST_CLEAR);
  assign wr_addr = vld_q ? addr_q : ((state_q == ST_CLEAR) ? cnt_q : '0);
  assign wr_data = vld_q ? merged : '0;

  // ---- stage 1 registers, forwarding copy of the last write, clear FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      carry_q     <= '0;
      vld_q       <= 1'b0;
      addr_q      <= '0;
      z_q         <= '0;
      pal_q       <= '0;
      pix_q       <= '0;
      prev_we_q   <= 1'b0;
      prev_addr_q <= '0;
      prev_data_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        addr_q  <= in_addr;
        z_q     <= in_z;
        pal_q   <= in_palette;
        pix_q   <= pix_d;
        carry_q <= in_tile[TILE_PIX*IDX_BITS-1 -: CAR_W];
      end
      prev_we_q   <= wr_en;
      prev_addr_q <= wr_addr;
      prev_data_q <= wr_data;
      done_q      <= 1'b0;
      case (state_q)
        ST_RUN: if (clear_start) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (!vld_q) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            carry_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

`ifdef PIXEL_COMPOSE_STATS_EN
  logic [15:0] stat_written_q;
  logic [15:0] stat_overdraw_q;
  logic [15:0] n_wr;
  logic [15:0] n_ov;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    n_wr = '0;
    n_ov = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      n_wr = n_wr + 16'(new_upd_v[k] & nz_v[k]);
      n_ov = n_ov + 16'(new_upd_v[k] & old_upd_v[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_written_q  <= '0;
      stat_overdraw_q <= '0;
    end else if (done_q) begin
      stat_written_q  <= '0;
      stat_overdraw_q <= '0;
    end else if (vld_q) begin
      stat_written_q  <= sat_add16(stat_written_q, n_wr);
      stat_overdraw_q <= sat_add16(stat_overdraw_q, n_ov);
    end
  end

  assign stat_written  = stat_written_q;
  assign stat_overdraw = stat_overdraw_q;
`endif

endmodule

// File: tb/tb_pixel_compose_pipe.sv
// Directed bench for pixel_compose_pipe with a behavioural line-buffer RAM.
module tb_pixel_compose_pipe;
  import gpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, in_ready, in_start, in_upper;
  logic [1:0]          in_offset;
  logic [1:0]          in_z;
  logic [3:0]          in_palette;
  logic [31:0]         in_tile;
  logic [5:0]          in_addr;
  logic                rd_en, wr_en;
  logic [5:0]          rd_addr, wr_addr;
  logic [LB_W-1:0]     rd_data = '0;
  logic [LB_W-1:0]     wr_data;
  logic                clear_start, clear_busy, clear_done;

  logic [LB_W-1:0]     mem [64] = '{default: '0};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_compose_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_upper(in_upper),
    .in_offset(in_offset), .in_z(in_z), .in_palette(in_palette), .in_tile(in_tile),
    .in_addr(in_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  // Line-buffer RAM: read latency 1, read-before-write on a collision.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic st, input logic up, input logic [1:0] off, input logic [1:0] z,
                      input logic [3:0] pal, input logic [31:0] tile, input logic [5:0] addr,
                      input logic hold);
    in_valid = 1'b1; in_start = st; in_upper = up; in_offset = off;
    in_z = z; in_palette = pal; in_tile = tile; in_addr = addr;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [5:0] addr, input logic [LB_W-1:0] data);
    check({tag, ".wr_en"},   64'(wr_en),   64'(1'b1));
    check({tag, ".wr_addr"}, 64'(wr_addr), 64'(addr));
    check({tag, ".wr_data"}, 64'(wr_data), 64'(data));
  endtask

  initial begin
    int  nw, addr_bad, ready_bad, stray;
    logic done_seen, done_ok, last_we, found;

    rst_n = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_upper = 1'b0; in_offset = '0;
    in_z = '0; in_palette = '0; in_tile = '0; in_addr = '0; clear_start = 1'b0;
    #1;
    check("rst.in_ready",   64'(in_ready),   64'(1'b1));
    check("rst.rd_en",      64'(rd_en),      64'(1'b0));
    check("rst.wr_en",      64'(wr_en),      64'(1'b0));
    check("rst.clear_busy", 64'(clear_busy), 64'(1'b0));
    check("rst.clear_done", 64'(clear_done), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First beat of a run, empty buffer
    in_valid = 1'b1; in_start = 1'b1; in_upper = 1'b0; in_offset = 2'd0;
    in_z = 2'd1; in_palette = 4'hA; in_tile = 32'h87654321; in_addr = 6'd3;
    #1;
    check("t1.rd_en",   64'(rd_en),   64'(1'b1));
    check("t1.rd_addr", 64'(rd_addr), 64'(6'd3));
    @(posedge clk); #1; in_valid = 1'b0;
    check_wr("t1", 6'd3, 44'h55FA4A3A2A1);

    // Carry pixel 7 of the previous tile shifted in at offset 1
    send(1'b0, 1'b0, 2'd1, 2'd1, 4'hB, 32'h11111111, 6'd4, 1'b0);
    check_wr("t2", 6'd4, 44'h55FB1B1B1B8);

    // Z priority: lower z loses, higher z wins except on transparent pixels
    send(1'b1, 1'b0, 2'd0, 2'd2, 4'hC, 32'h00005555, 6'd6, 1'b0);
    check_wr("t3a", 6'd6, 44'hAAFC5C5C5C5);
    @(posedge clk); #1;
    send(1'b1, 1'b0, 2'd0, 2'd1, 4'hD, 32'h00009999, 6'd6, 1'b0);
    check_wr("t3b", 6'd6, 44'hAAFC5C5C5C5);
    @(posedge clk); #1;
    send(1'b1, 1'b0, 2'd0, 2'd3, 4'hE, 32'h00007077, 6'd6, 1'b0);
    check_wr("t3c", 6'd6, 44'hEFFE7C5E7E7);

    // Back-to-back beats to one word must chain through forwarding
    send(1'b1, 1'b0, 2'd0, 2'd1, 4'h2, 32'h00003333, 6'd5, 1'b1);
    check_wr("t4a", 6'd5, 44'h55F23232323);
    send(1'b1, 1'b0, 2'd0, 2'd2, 4'h4, 32'h00006660, 6'd5, 1'b0);
    check_wr("t4b", 6'd5, 44'hA9F46464623);
    @(posedge clk); #1;
    check("t4.mem5", 64'(mem[5]), 64'(44'hA9F46464623));

    // Upper alignment window
    send(1'b1, 1'b1, 2'd0, 2'd1, 4'h3, 32'h87654321, 6'd9, 1'b0);
    check_wr("tup", 6'd9, 44'h55F38373635);

    // Clear requested while a beat sits in stage 2
    send(1'b1, 1'b0, 2'd0, 2'd1, 4'h1, 32'h11111111, 6'd7, 1'b0);
    clear_start = 1'b1;
    #1;
    check_wr("t5.pending", 6'd7, 44'h55F11111111);
    check("t5.ready_at_req", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1; clear_start = 1'b0;
    check("t5.busy", 64'(clear_busy), 64'(1'b1));
    nw = 0; addr_bad = 0; ready_bad = 0; done_seen = 1'b0; done_ok = 1'b0; last_we = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      if (clear_done) begin
        done_seen = 1'b1;
        done_ok   = (nw == DEPTH) && !wr_en && last_we;
      end else if (in_ready) begin
        ready_bad++;
      end
      if (wr_en) begin
        if (wr_addr != 6'(nw) || wr_data != '0) addr_bad++;
        nw++;
      end
      last_we = wr_en;
      @(posedge clk); #1;
    end
    check("t5.done_seen",   64'(done_seen), 64'(1'b1));
    check("t5.done_timing", 64'(done_ok),   64'(1'b1));
    check("t5.clear_count", 64'(nw),        64'(DEPTH));
    check("t5.addr_errs",   64'(addr_bad),  64'(0));
    check("t5.ready_low",   64'(ready_bad), 64'(0));
    check("t5.ready_after", 64'(in_ready),  64'(1'b1));
    check("t5.busy_after",  64'(clear_busy), 64'(1'b0));
    check("t5.mem7", 64'(mem[7]), 64'(0));
    check("t5.mem3", 64'(mem[3]), 64'(0));

    // Clear also drops the carry
    send(1'b0, 1'b0, 2'd3, 2'd1, 4'hF, 32'h00000009, 6'd8, 1'b0);
    check_wr("tcarry", 6'd8, 44'h55FF9F0F0F0);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (wr_en && wr_addr == 6'd10) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t6.reached_10", 64'(found), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t6.wr_en",  64'(wr_en),      64'(1'b0));
    check("t6.busy",   64'(clear_busy), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6.ready", 64'(in_ready), 64'(1'b1));
    stray = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (wr_en) stray++;
    end
    check("t6.no_writes", 64'(stray), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
